axil_lsu_master: RTL and testbench

//  AXI4-Lite initiator for the core load/store unit. Takes one simple

---
 rtl/axil_lsu_master_if.sv | 47 ++++
 rtl/axil_lsu_master.sv | 164 ++++++++++++++++
 tb/tb_axil_lsu_master.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_lsu_master_if.sv
// Bundles the LSU request/response handshake and the AXI4-Lite channels.
// The master modport is the initiator's view. The slave modport is the
// view of whoever drives requests and models the bus.
interface axil_lsu_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    input  resp_ready, arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    output resp_ready, arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
  );
endinterface

// File: rtl/axil_lsu_master.sv
// Purpose: AXI4-Lite initiator for the LSU. It handles one load or store at a time and returns extended load data or a completion.
// Latency: best case 3 cycles from accept to resp_valid. A misaligned or illegal request responds 1 cycle after accept.
// Backpressure: req_ready only in IDLE, resp held until resp_ready; optional bus timeout via AXIL_TIMEOUT_EN.
module axil_lsu_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  axil_lsu_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, rdata_q, load_ext;
  logic [3:0]  wstrb_q;
  logic [1:0]  size_q;
  logic        unsigned_q, aw_done, w_done, err_q;
  logic        req_fire, ar_fire, r_fire, aw_fire, w_fire, b_fire, resp_fire;
  logic        bad_req, busy, timeout;

  // Handshake fires are derived from state so they never loop through the output logic.
  assign req_fire  = (state == IDLE)  && bus.req_valid;
  assign ar_fire   = (state == RD_A)  && bus.arready;
  assign r_fire    = (state == RD_D)  && bus.rvalid;
  assign aw_fire   = (state == WR_AW) && !aw_done && bus.awready;
  assign w_fire    = (state == WR_AW) && !w_done && bus.wready;
  assign b_fire    = (state == WR_B)  && bus.bvalid;
  assign resp_fire = (state == DONE)  && bus.resp_ready;
  assign busy      = (state == RD_A) || (state == RD_D) || (state == WR_AW) || (state == WR_B);

  // Requests that must not reach the bus: size 3, or an address not aligned to the access size.
  assign bad_req = (bus.req_size == 2'd3) ||
                   ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                   ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));

`ifdef AXIL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  // Bring-up watchdog: counts bus cycles of the current transaction from its accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           to_cnt <= '0;
    else if (req_fire) to_cnt <= '0;
    else if (busy)     to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = busy && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  // The timeout length has no effect unless the watchdog is built in.
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  // State register; an async reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.arvalid    = 1'b0;
    bus.rready     = 1'b0;
    bus.awvalid    = 1'b0;
    bus.wvalid     = 1'b0;
    bus.bready     = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (req_fire) state_nxt = bad_req ? DONE : (bus.req_wen ? WR_AW : RD_A);
      end
      RD_A: begin
        bus.arvalid = 1'b1;
        if (ar_fire) state_nxt = RD_D;
      end
      RD_D: begin
        bus.rready = 1'b1;
        if (r_fire) state_nxt = DONE;
      end
      WR_AW: begin
        bus.awvalid = !aw_done;
        bus.wvalid  = !w_done;
        if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = WR_B;
      end
      WR_B: begin
        bus.bready = 1'b1;
        if (b_fire) state_nxt = DONE;
      end
      DONE: begin
        bus.resp_valid = 1'b1;
        if (resp_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = DONE;
  end

  // Shift the addressed lane down to bit 0, then sign- or zero-extend sub-word loads.
  always_comb begin
    logic [31:0] shifted;
    shifted  = bus.rdata >> {addr_q[1:0], 3'b000};
    load_ext = shifted;
    case (size_q)
      2'd0:    load_ext = unsigned_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = unsigned_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Latch request fields at accept, track AW/W completion, and capture the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (req_fire) begin
        addr_q     <= bus.req_addr;
        wdata_q    <= bus.req_wdata << {bus.req_addr[1:0], 3'b000};
        size_q     <= bus.req_size;
        unsigned_q <= bus.req_unsigned;
        case (bus.req_size)
          2'd0:    wstrb_q <= 4'b0001 << bus.req_addr[1:0];
          2'd1:    wstrb_q <= 4'b0011 << bus.req_addr[1:0];
          default: wstrb_q <= 4'b1111 << bus.req_addr[1:0];
        endcase
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        rdata_q <= '0;
        err_q   <= bad_req;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
      if (r_fire) begin
        rdata_q <= load_ext;
        err_q   <= (bus.rresp != 2'b00);
      end
      if (b_fire) err_q <= (bus.bresp != 2'b00);
      if (timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign bus.araddr     = addr_q;
  assign bus.awaddr     = addr_q;
  assign bus.wdata      = wdata_q;
  assign bus.wstrb      = wstrb_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_axil_lsu_master.sv
// Directed bench for axil_lsu_master. It uses a reactive AXI4-Lite slave with per-channel delays.
// A per-cycle compare process checks the DUT against a transaction-level model.
// Literal expectations pin the model itself.
module tb_axil_lsu_master;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axil_lsu_master_if bus();
  axil_lsu_master #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // slave behaviour knobs
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0, rsp_dly = 0;
  logic [31:0] slv_rdata = 32'h0;
  logic [1:0]  slv_rresp = 2'b00, slv_bresp = 2'b00;

  // model state for the transaction in flight
  logic        busy = 1'b0, seen_resp;
  int          lat, exp_lat, off, nb;
  logic        exp_wen, exp_bad, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_wstrb;
  longint      v;
  int          hs_cnt = 0;
  logic [31:0] last_rdata, last_awaddr, last_wdata;
  logic [3:0]  last_wstrb;
  logic        last_err;
  int          last_lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reactive slave: each ready/valid rises after the configured number of waiting cycles.
  initial begin
    int ar_c, r_c, aw_c, w_c, b_c, p_c;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0; p_c = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0; bus.resp_ready = 0;
    forever begin
      @(posedge clk); #1;
      ar_c = bus.arvalid ? ar_c + 1 : 0;
      bus.arready = bus.arvalid && (ar_c > ar_dly);
      r_c = bus.rready ? r_c + 1 : 0;
      bus.rvalid = bus.rready && (r_c > r_dly);
      bus.rdata  = bus.rvalid ? slv_rdata : 32'h0;
      bus.rresp  = slv_rresp;
      aw_c = bus.awvalid ? aw_c + 1 : 0;
      bus.awready = bus.awvalid && (aw_c > aw_dly);
      w_c = bus.wvalid ? w_c + 1 : 0;
      bus.wready = bus.wvalid && (w_c > w_dly);
      b_c = bus.bready ? b_c + 1 : 0;
      bus.bvalid = bus.bready && (b_c > b_dly);
      bus.bresp  = slv_bresp;
      p_c = bus.resp_valid ? p_c + 1 : 0;
      bus.resp_ready = bus.resp_valid && (p_c > rsp_dly);
    end
  end

  // Compare process: outputs are sampled on the falling edge against the transaction model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0;
      end else begin
        check("req_ready", bus.req_ready, !busy);
        if (busy) lat++;
        if (bus.arvalid) begin
          check("ar_busy", busy, 1);
          check("ar_kind", {exp_wen, exp_bad}, 2'b00);
          check("araddr", bus.araddr, exp_addr);
        end
        if (bus.awvalid) begin
          check("aw_kind", {!exp_wen, exp_bad}, 2'b00);
          check("awaddr", bus.awaddr, exp_addr);
          last_awaddr = bus.awaddr;
        end
        if (bus.wvalid) begin
          check("w_kind", {!exp_wen, exp_bad}, 2'b00);
          check("wdata", bus.wdata, exp_wdata);
          check("wstrb", bus.wstrb, exp_wstrb);
          last_wdata = bus.wdata;
          last_wstrb = bus.wstrb;
        end
        if (busy && bus.resp_valid && !seen_resp) begin
          check("resp_latency", lat, exp_lat);
          seen_resp = 1'b1;
          last_lat  = lat;
        end
        if (bus.resp_valid && bus.resp_ready) begin
          check("resp_solicited", busy, 1);
          check("resp_rdata", bus.resp_rdata, exp_rdata);
          check("resp_err", bus.resp_err, exp_err);
          last_rdata = bus.resp_rdata;
          last_err   = bus.resp_err;
          hs_cnt++;
          busy = 1'b0;
        end
        if (bus.req_valid && bus.req_ready) begin
          busy = 1'b1; lat = 0; seen_resp = 1'b0;
          exp_wen  = bus.req_wen;
          exp_addr = bus.req_addr;
          off = int'(bus.req_addr[1:0]);
          nb  = (bus.req_size == 2'd3) ? 0 : (1 << bus.req_size);
          exp_bad   = (nb == 0) ? 1'b1 : ((off % nb) != 0);
          exp_wstrb = 4'(((1 << nb) - 1) << off);
          exp_wdata = bus.req_wdata << (8 * off);
          if (exp_bad) begin
            exp_lat = 1; exp_err = 1'b1; exp_rdata = 32'h0;
          end else if (exp_wen) begin
            exp_lat   = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
            exp_err   = (slv_bresp != 2'b00);
            exp_rdata = 32'h0;
          end else begin
            exp_lat = 3 + ar_dly + r_dly;
            exp_err = (slv_rresp != 2'b00);
            v = longint'(slv_rdata >> (8 * off));
            if (nb < 4) begin
              v = v % (64'sd1 <<< (8 * nb));
              if (!bus.req_unsigned && v >= (64'sd1 <<< (8 * nb - 1))) v = v - (64'sd1 <<< (8 * nb));
            end
            exp_rdata = 32'(v);
          end
`ifdef AXIL_TIMEOUT_EN
          if (!exp_bad && (exp_lat - 1 >= TO)) begin
            exp_lat = TO + 1; exp_err = 1'b1; exp_rdata = 32'h0;
          end
`endif
        end
      end
    end
  end

  task automatic send(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] sz, input logic uns);
    @(posedge clk); #1;
    bus.req_wen = wen; bus.req_addr = addr; bus.req_wdata = wd;
    bus.req_size = sz; bus.req_unsigned = uns; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    // scrambled fields must be ignored once the request is latched
    bus.req_wen = ~wen; bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_size = 2'd3; bus.req_unsigned = ~uns;
  endtask

  task automatic wait_resp(input string name);
    int start;
    start = hs_cnt;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (hs_cnt != start) break;
    end
    repeat (2) @(posedge clk);
    #2;
    check({name, "_handshakes"}, hs_cnt - start, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 0; bus.req_wen = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_size = 0; bus.req_unsigned = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_awvalid", bus.awvalid, 0);
    check("rst_wvalid", bus.wvalid, 0);
    check("rst_rready", bus.rready, 0);
    check("rst_bready", bus.bready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_err", bus.resp_err, 0);
    @(posedge clk); #1 rst = 1'b0;

    // lw with a 3-cycle slave data delay
    slv_rdata = 32'hDEAD_BEEF; r_dly = 3;
    send(0, 32'h8000_0004, 0, 2'd2, 0); wait_resp("lw");
    check("lw_data", last_rdata, 32'hDEAD_BEEF);
    check("lw_err", last_err, 0);
    check("lw_lat", last_lat, 6);
    r_dly = 0;
    send(0, 32'h8000_0008, 0, 2'd2, 0); wait_resp("lw_fast");
    check("lw_fast_lat", last_lat, 3);

    // sub-word loads: lane select and extension
    slv_rdata = 32'h80FF_FFFF;
    send(0, 32'h8000_0003, 0, 2'd0, 0); wait_resp("lb");
    check("lb_data", last_rdata, 32'hFFFF_FF80);
    send(0, 32'h8000_0002, 0, 2'd1, 1); wait_resp("lhu");
    check("lhu_data", last_rdata, 32'h0000_80FF);
    send(0, 32'h8000_0002, 0, 2'd1, 0); wait_resp("lh");
    check("lh_data", last_rdata, 32'hFFFF_80FF);
    rsp_dly = 3; ar_dly = 2;
    send(0, 32'h8000_0001, 0, 2'd0, 1); wait_resp("lbu");
    check("lbu_data", last_rdata, 32'h0000_00FF);
    rsp_dly = 0; ar_dly = 0;
    slv_rresp = 2'b10;
    send(0, 32'h8000_0000, 0, 2'd2, 0); wait_resp("lw_slverr");
    check("lw_slverr_err", last_err, 1);
    check("lw_slverr_data", last_rdata, 32'h80FF_FFFF);
    slv_rresp = 2'b00;

    // stores: AW before W, W before AW, and both in the same cycle
    aw_dly = 0; w_dly = 2;
    send(1, 32'hA000_03F9, 32'h0000_0041, 2'd0, 0); wait_resp("sb");
    check("sb_awaddr", last_awaddr, 32'hA000_03F9);
    check("sb_wstrb", last_wstrb, 4'b0010);
    check("sb_wdata", last_wdata, 32'h0000_4100);
    check("sb_lat", last_lat, 5);
    aw_dly = 2; w_dly = 0;
    send(1, 32'hA000_0100, 32'h1234_5678, 2'd2, 0); wait_resp("sw");
    check("sw_wstrb", last_wstrb, 4'b1111);
    aw_dly = 0; b_dly = 1; slv_bresp = 2'b10;
    send(1, 32'hA000_0102, 32'h0000_BEEF, 2'd1, 0); wait_resp("sh_slverr");
    check("sh_wdata", last_wdata, 32'hBEEF_0000);
    check("sh_wstrb", last_wstrb, 4'b1100);
    check("sh_err", last_err, 1);
    check("sh_lat", last_lat, 4);
    b_dly = 0; slv_bresp = 2'b00;

    // requests rejected without bus traffic
    send(0, 32'h8000_0002, 0, 2'd2, 0); wait_resp("lw_misaligned");
    check("mis_err", last_err, 1);
    check("mis_data", last_rdata, 0);
    check("mis_lat", last_lat, 1);
    send(1, 32'h8000_0000, 32'h1, 2'd3, 0); wait_resp("size3");
    check("size3_err", last_err, 1);

    // reset while waiting for read data
    r_dly = 5;
    send(0, 32'h8000_0010, 0, 2'd2, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (bus.rready) break;
    end
    check("rd_d_reached", bus.rready, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_arvalid", bus.arvalid, 0);
    check("mid_rst_rready", bus.rready, 0);
    check("mid_rst_resp_valid", bus.resp_valid, 0);
    check("mid_rst_req_ready", bus.req_ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    r_dly = 0; slv_rdata = 32'hCAFE_F00D;
    send(0, 32'h8000_0014, 0, 2'd2, 0); wait_resp("lw_after_rst");
    check("after_rst_data", last_rdata, 32'hCAFE_F00D);

`ifdef AXIL_TIMEOUT_EN
    ar_dly = 50;
    send(0, 32'h8000_0020, 0, 2'd2, 0); wait_resp("timeout");
    check("timeout_err", last_err, 1);
    check("timeout_lat", last_lat, TO + 1);
    ar_dly = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d tests run", tests);
    $fatal(1);
  end
endmodule
